// File: rtl/multi_input_conditioner_if.sv
// Pin-side bundle for the multi-channel input conditioner: raw pins and flag
// clears in, debounced levels, edge pulses and sticky flags out.
interface multi_input_conditioner_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] noisysignal;
  logic [NCH-1:0] flag_clr;
  logic [NCH-1:0] conditioned;
  logic [NCH-1:0] positiveedge;
  logic [NCH-1:0] negativeedge;
  logic [NCH-1:0] edge_flags;
  logic           any_edge;

  modport master (
    output noisysignal, flag_clr,
    input  conditioned, positiveedge, negativeedge, edge_flags, any_edge
  );

  modport slave (
    input  noisysignal, flag_clr,
    output conditioned, positiveedge, negativeedge, edge_flags, any_edge
  );
endinterface

// File: rtl/multi_input_conditioner.sv
// N independent channels of invert -> synchronize -> debounce -> edge pulse,
// with sticky write-one-to-clear edge flags and an aggregate event output.
module multi_input_conditioner #(
  parameter int             NCH        = 4,
  parameter int             SYNC_DEPTH = 2,
  parameter int             WAIT_TIME  = 3,
  parameter int             CNT_W      = 3,
  parameter logic [NCH-1:0] INVERT     = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  multi_input_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_TIME);

  if (SYNC_DEPTH < 2) begin : g_bad_sync_depth
    $error("multi_input_conditioner: SYNC_DEPTH must be at least 2");
  end
  if ((2 ** CNT_W) <= WAIT_TIME) begin : g_bad_cnt_w
    $error("multi_input_conditioner: CNT_W too narrow to hold WAIT_TIME");
  end

  logic [NCH-1:0] cond_q;
  logic [NCH-1:0] pos_q;
  logic [NCH-1:0] neg_q;
  logic [NCH-1:0] flags_q;
  logic           any_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  cond_r;
    logic                  pos_r;
    logic                  neg_r;
    logic                  sync;

    assign sync = sync_q[SYNC_DEPTH-1];

    // The counter only advances while the synchronized level disagrees with
    // the committed one, so any return to agreement restarts the debounce.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        cnt_q  <= '0;
        cond_r <= 1'b0;
        pos_r  <= 1'b0;
        neg_r  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_DEPTH-2:0], bus.noisysignal[i] ^ INVERT[i]};
        if (sync == cond_r) begin
          cnt_q <= '0;
          pos_r <= 1'b0;
          neg_r <= 1'b0;
        end else if (cnt_q != WAIT_CNT) begin
          cnt_q <= cnt_q + 1'b1;
          pos_r <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          cnt_q  <= '0;
          cond_r <= sync;
          pos_r  <= sync;
          neg_r  <= ~sync;
        end
      end
    end

    assign cond_q[i] = cond_r;
    assign pos_q[i]  = pos_r;
    assign neg_q[i]  = neg_r;
  end

  // A new edge takes priority over a clear in the same cycle so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      any_q   <= 1'b0;
    end else begin
      flags_q <= pos_q | neg_q | (flags_q & ~bus.flag_clr);
      any_q   <= |flags_q;
    end
  end

  assign bus.conditioned  = cond_q;
  assign bus.positiveedge = pos_q;
  assign bus.negativeedge = neg_q;
  assign bus.edge_flags   = flags_q;
  assign bus.any_edge     = any_q;

endmodule
